// File: rtl/fc_layer_sched.sv
// Fully-connected layer sequencer: walks output nodes through input chunks, bias, then write.
// Define FC_SCHED_PERF_EN to add the 16-bit busy-cycle counter output perf_cycles.
module fc_layer_sched #(
    parameter int unsigned INPUT_NODES  = 784,
    parameter int unsigned OUTPUT_NODES = 2,
    parameter int unsigned MAC_UNITS    = 16,
    parameter int unsigned PIPE_LAT     = 2,
    parameter int unsigned ADDR_W       = 7,
    localparam int unsigned ROUNDS      = INPUT_NODES / MAC_UNITS,
    localparam int unsigned RW          = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
    localparam int unsigned NW          = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              pipe_en,
    output logic              issue_vld,
    output logic [RW-1:0]     in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              bias_sel,
    output logic [NW-1:0]     node_idx,
    output logic              out_wr
`ifdef FC_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [RW-1:0]       round_q;
    logic [NW-1:0]       node_q;
    logic [2:0]          drain_q;
    logic [ADDR_W-1:0]   w_addr_q;
    logic                issue_q;
    logic                busy_q;
    logic                bias_q;
    logic                wr_q;
    logic                done_q;
    logic [PIPE_LAT-1:0] vld_q;
    logic [PIPE_LAT-1:0] vld_d;
    logic [PIPE_LAT-1:0] first_q;
    logic [PIPE_LAT-1:0] first_d;
    logic                adv;

    // Stall is ignored in IDLE so a start can always be accepted.
    assign adv = !stall || (state_q == S_IDLE);

    // first_q tags the round-0 issue of each node so acc_clr lines up with its acc_en.
    always_comb begin
        vld_d      = vld_q << 1;
        vld_d[0]   = issue_q;
        first_d    = first_q << 1;
        first_d[0] = issue_q && (round_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            node_q   <= '0;
            drain_q  <= '0;
            w_addr_q <= '0;
            issue_q  <= 1'b0;
            busy_q   <= 1'b0;
            bias_q   <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            vld_q    <= '0;
            first_q  <= '0;
        end else begin
            if (!stall) begin
                vld_q   <= vld_d;
                first_q <= first_d;
            end
            if (adv) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q  <= S_ISSUE;
                            round_q  <= '0;
                            node_q   <= '0;
                            w_addr_q <= '0;
                            issue_q  <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (round_q == RW'(ROUNDS - 1)) begin
                            state_q <= S_DRAIN;
                            issue_q <= 1'b0;
                            drain_q <= '0;
                        end else begin
                            round_q  <= round_q + 1'b1;
                            w_addr_q <= w_addr_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_q == 3'(PIPE_LAT - 1)) begin
                            state_q <= S_BIAS;
                            bias_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    S_BIAS: begin
                        state_q <= S_WRITE;
                        bias_q  <= 1'b0;
                        wr_q    <= 1'b1;
                    end
                    S_WRITE: begin
                        wr_q <= 1'b0;
                        // Weight rows are contiguous per node, so the next node starts one past the last row.
                        if (node_q != NW'(OUTPUT_NODES - 1)) begin
                            state_q  <= S_ISSUE;
                            node_q   <= node_q + 1'b1;
                            round_q  <= '0;
                            w_addr_q <= w_addr_q + 1'b1;
                            issue_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pipe_en   = !stall;
    assign busy      = busy_q;
    assign done      = done_q && !stall;
    assign issue_vld = issue_q && !stall;
    assign in_addr   = round_q;
    assign w_addr    = w_addr_q;
    assign acc_en    = (vld_q[PIPE_LAT-1] || bias_q) && !stall;
    assign acc_clr   = first_q[PIPE_LAT-1] && vld_q[PIPE_LAT-1] && !stall;
    assign bias_sel  = bias_q && !stall;
    assign node_idx  = node_q;
    assign out_wr    = wr_q && !stall;

`ifdef FC_SCHED_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            perf_q <= '0;
        end else if (busy_q && perf_q != '1) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fc_layer_sched.sv
// Directed bench for fc_layer_sched: default build plus a small PIPE_LAT=4 configuration.
`timescale 1ns/1ps
module tb_fc_layer_sched;

    logic       clk = 1'b0;
    logic       reset, start, stall, start2, stall2;
    logic       busy, done, pipe_en, issue_vld, acc_en, acc_clr, bias_sel, out_wr;
    logic [5:0] in_addr;
    logic [6:0] w_addr;
    logic [0:0] node_idx;
    logic       busy2, done2, pipe_en2, issue_vld2, acc_en2, acc_clr2, bias_sel2, out_wr2;
    logic [1:0] in_addr2;
    logic [3:0] w_addr2;
    logic [1:0] node_idx2;
`ifdef FC_SCHED_PERF_EN
    logic [15:0] perf_cycles, perf_cycles2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_layer_sched dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy), .done(done), .pipe_en(pipe_en), .issue_vld(issue_vld),
        .in_addr(in_addr), .w_addr(w_addr), .acc_en(acc_en), .acc_clr(acc_clr),
        .bias_sel(bias_sel), .node_idx(node_idx), .out_wr(out_wr)
`ifdef FC_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    fc_layer_sched #(
        .INPUT_NODES(64), .OUTPUT_NODES(3), .MAC_UNITS(16), .PIPE_LAT(4), .ADDR_W(4)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stall(stall2),
        .busy(busy2), .done(done2), .pipe_en(pipe_en2), .issue_vld(issue_vld2),
        .in_addr(in_addr2), .w_addr(w_addr2), .acc_en(acc_en2), .acc_clr(acc_clr2),
        .bias_sel(bias_sel2), .node_idx(node_idx2), .out_wr(out_wr2)
`ifdef FC_SCHED_PERF_EN
        , .perf_cycles(perf_cycles2)
`endif
    );

    // Activity monitors: expected addresses restart whenever the scheduler is not busy.
    int n_issue = 0, n_acc = 0, n_clr = 0, n_bias = 0, n_wr = 0, n_done = 0, n_bad = 0;
    int exp_w = 0, wmax = 0, wr_prev = -1, wr_last = -1;
    int n2_issue = 0, n2_acc = 0, n2_clr = 0, n2_wr = 0, w2max = 0;

    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            exp_w = 0;
            wmax  = 0;
        end
        if (issue_vld === 1'b1) begin
            n_issue++;
            if (int'(w_addr) != exp_w) n_bad++;
            if (int'(in_addr) != exp_w % 49) n_bad++;
            if (int'(w_addr) > wmax) wmax = int'(w_addr);
            exp_w++;
        end
        if (acc_en === 1'b1) n_acc++;
        if (acc_clr === 1'b1) begin
            n_clr++;
            if (acc_en !== 1'b1) n_bad++;
        end
        if (bias_sel === 1'b1) n_bias++;
        if (out_wr === 1'b1) begin
            n_wr++;
            wr_prev = wr_last;
            wr_last = int'(node_idx);
        end
        if (done === 1'b1) n_done++;
        if (issue_vld2 === 1'b1) begin
            n2_issue++;
            if (int'(w_addr2) > w2max) w2max = int'(w_addr2);
        end
        if (acc_en2 === 1'b1) n2_acc++;
        if (acc_clr2 === 1'b1) n2_clr++;
        if (out_wr2 === 1'b1) n2_wr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int outs1();
        return int'({busy, done, issue_vld, acc_en, acc_clr, bias_sel, out_wr, in_addr, w_addr, node_idx});
    endfunction

    // One job on the default instance; optional stall burst at a node-0 round, or stall during the accept cycle.
    task automatic run_job(input string tag, input int stall_at, input int stall_len,
                           input bit stall_idle, output int lat);
        int  s_issue, s_acc, s_clr, s_bias, s_wr, s_bad, s_done;
        bit  stalled;
        s_issue = n_issue; s_acc = n_acc; s_clr = n_clr; s_bias = n_bias;
        s_wr = n_wr; s_bad = n_bad; s_done = n_done;
        stalled = 1'b0;
        start = 1'b1;
        if (stall_idle) stall = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b0;
        #1;
        chk({tag, ".busy_after_accept"}, int'(busy), 1);
        lat = 1;
        while (lat < 1000) begin
            if (done === 1'b1) break;
            if (!stalled && stall_len > 0 && issue_vld === 1'b1 && int'(in_addr) == stall_at) begin
                stalled = 1'b1;
                for (int i = 0; i < stall_len; i++) begin
                    stall = 1'b1;
                    #1;
                    chk({tag, ".stall_issue"}, int'(issue_vld), 0);
                    chk({tag, ".stall_acc"}, int'(acc_en), 0);
                    chk({tag, ".stall_in_addr"}, int'(in_addr), stall_at);
                    chk({tag, ".stall_w_addr"}, int'(w_addr), stall_at);
                    tick();
                    lat++;
                end
                stall = 1'b0;
                #1;
                chk({tag, ".resume_issue"}, int'(issue_vld), 1);
                chk({tag, ".resume_in_addr"}, int'(in_addr), stall_at);
            end
            tick();
            lat++;
        end
        chk({tag, ".busy_in_done"}, int'(busy), 0);
        chk({tag, ".issues"}, n_issue - s_issue, 98);
        chk({tag, ".acc_en"}, n_acc - s_acc, 100);
        chk({tag, ".acc_clr"}, n_clr - s_clr, 2);
        chk({tag, ".bias_sel"}, n_bias - s_bias, 2);
        chk({tag, ".writes"}, n_wr - s_wr, 2);
        chk({tag, ".wr_order"}, wr_prev * 10 + wr_last, 1);
        chk({tag, ".addr_seq"}, n_bad - s_bad, 0);
        chk({tag, ".w_addr_max"}, wmax, 97);
`ifdef FC_SCHED_PERF_EN
        chk({tag, ".perf"}, int'(perf_cycles), 106 + stall_len);
`endif
        tick();
        chk({tag, ".done_pulse"}, n_done - s_done, 1);
        chk({tag, ".done_low"}, int'(done), 0);
`ifdef FC_SCHED_PERF_EN
        chk({tag, ".perf_hold"}, int'(perf_cycles), 106 + stall_len);
`endif
    endtask

    initial begin
        int lat, d1, d2, s_wr, s_done, n, f_iss, f_acc;
        reset = 1'b1; start = 1'b0; stall = 1'b0; start2 = 1'b0; stall2 = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("por.outs", outs1(), 0);
        reset = 1'b0;
        #1;
        chk("por.pipe_en", int'(pipe_en), 1);
        stall = 1'b1;
        #1;
        chk("stall.pipe_en", int'(pipe_en), 0);
        tick();
        stall = 1'b0;
        chk("idle.busy", int'(busy), 0);

        run_job("basic", 0, 0, 1'b0, lat);
        chk("basic.latency", lat, 107);
        run_job("stall5", 20, 5, 1'b0, lat);
        chk("stall5.latency", lat, 112);
        run_job("idle_stall", 0, 0, 1'b1, lat);
        chk("idle_stall.latency", lat, 107);

        // Abort in the first DRAIN cycle of node 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 103) begin
            tick();
            n++;
        end
        chk("abort.busy", int'(busy), 1);
        chk("abort.node", int'(node_idx), 1);
        chk("abort.issue", int'(issue_vld), 0);
        chk("abort.acc", int'(acc_en), 1);
        s_wr = n_wr;
        s_done = n_done;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort.outs", outs1(), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort.no_write", n_wr - s_wr, 0);
        chk("abort.no_done", n_done - s_done, 0);
        run_job("after_abort", 0, 0, 1'b0, lat);
        chk("after_abort.latency", lat, 107);

        // start held high: jobs run back to back.
        start = 1'b1;
        tick();
        n = 1; d1 = 0; d2 = 0;
        while (n < 1000 && d2 == 0) begin
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = n;
                    tick(); n++;
                    chk("b2b.idle_gap_busy", int'(busy), 0);
                    tick(); n++;
                    chk("b2b.restart_busy", int'(busy), 1);
                end else begin
                    d2 = n;
                    start = 1'b0;
                end
            end
            if (d2 == 0) begin
                tick();
                n++;
            end
        end
        chk("b2b.first_done", d1, 107);
        chk("b2b.done_spacing", d2 - d1, 108);
        tick();
        tick();
        chk("b2b.stops", int'(busy), 0);

        // Small configuration: 4 rounds, PIPE_LAT=4, 3 nodes.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1; f_iss = 0; f_acc = 0;
        while (n < 200) begin
            if (f_iss == 0 && issue_vld2 === 1'b1) f_iss = n;
            if (f_acc == 0 && acc_en2 === 1'b1) f_acc = n;
            if (done2 === 1'b1) break;
            tick();
            n++;
        end
        chk("cfg2.latency", n, 31);
        chk("cfg2.first_issue", f_iss, 1);
        chk("cfg2.first_acc", f_acc, 5);
        chk("cfg2.issues", n2_issue, 12);
        chk("cfg2.acc_en", n2_acc, 15);
        chk("cfg2.acc_clr", n2_clr, 3);
        chk("cfg2.writes", n2_wr, 3);
        chk("cfg2.w_addr_max", w2max, 11);

`ifdef FC_SCHED_PERF_EN
        run_job("perf3", 10, 3, 1'b0, lat);
        chk("perf3.latency", lat, 110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_sched.md
Name: fc_layer_sched

Overview:
- Sequencer for the fully-connected layer datapath (MAC array plus output accumulator).
- Walks every output node through all input chunks, then adds bias, then writes the result.
- Drives weight/input buffer addresses, issue-valid, accumulator control and result-write strobes.
- Sits between the layer-level start/done handshake and the FC compute pipeline. Holds no arithmetic.

Parameters:
- INPUT_NODES, 784, input vector length; must be an integer multiple of MAC_UNITS.
- OUTPUT_NODES, 2, number of output neurons.
- MAC_UNITS, 16, elements consumed per issue cycle.
- PIPE_LAT, 2, cycles from issue to datapath result valid; allowed range 1..8.
- ADDR_W, 7, weight address width; must satisfy 2^ADDR_W >= OUTPUT_NODES*ROUNDS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level or pulse; sampled in IDLE only.
- stall  in  1  freezes the scheduler and the datapath enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last write.
- pipe_en  out  1  equals !stall; the datapath pipeline advances only when high.
- issue_vld  out  1  the current in_addr/w_addr pair is valid.
- in_addr  out  $clog2(ROUNDS)  input chunk index.
- w_addr  out  ADDR_W  weight row address.
- acc_en  out  1  accumulator captures the datapath result (or bias).
- acc_clr  out  1  accumulator loads instead of adds; qualifies acc_en.
- bias_sel  out  1  accumulator source is bias, not MAC result.
- node_idx  out  $clog2(OUTPUT_NODES)  node currently being computed.
- out_wr  out  1  write the accumulator to the output register at node_idx.

Behaviour:
- ROUNDS = INPUT_NODES/MAC_UNITS; 49 at defaults.
- Reset (synchronous, active-high) forces:
  - state IDLE;
  - round, node and drain counters to 0;
  - valid shift register to 0;
  - busy, done, issue_vld, acc_en, acc_clr, bias_sel, out_wr to 0;
  - in_addr, w_addr, node_idx to 0.
- Reset mid-operation aborts immediately. No write or done pulse follows.
- FSM states: IDLE, ISSUE, DRAIN, BIAS, WRITE, DONE.
- IDLE:
  - start=1 -> ISSUE next cycle, with node=0 and round=0.
  - start is ignored in every other state.
- ISSUE:
  - issue_vld=1, in_addr=round, w_addr=node*ROUNDS+round.
  - round increments each unstalled cycle.
  - After round ROUNDS-1 -> DRAIN.
- Valid pipeline:
  - issue_vld is delayed PIPE_LAT unstalled cycles to produce acc_en.
  - acc_clr is high with the first acc_en of each node.
- DRAIN:
  - Waits PIPE_LAT unstalled cycles, until the final delayed valid has produced acc_en.
  - Then -> BIAS.
- BIAS:
  - One cycle with acc_en=1 and bias_sel=1.
  - -> WRITE.
- WRITE:
  - One cycle with out_wr=1, node_idx=node.
  - If node<OUTPUT_NODES-1: node++, round=0, -> ISSUE.
  - Otherwise -> DONE.
- DONE:
  - done=1 for one cycle, busy=0 in this cycle.
  - -> IDLE. A new start is accepted in the following cycle.
- busy is 1 in ISSUE, DRAIN, BIAS and WRITE.
- Per-node cycle count, unstalled: ROUNDS+PIPE_LAT+2 = 53.
- Latency, start accepted to done: OUTPUT_NODES*53+1 = 107 cycles at defaults.
- stall=1 behaviour:
  - All state, counters and the valid shift register hold.
  - issue_vld, acc_en, out_wr and bias_sel are forced to 0 in that cycle.
  - Addresses hold their value.
  - stall during IDLE has no effect; start is still accepted.
  - stall in DONE delays the done pulse.
- Simultaneous reset and start: reset wins.
- w_addr never exceeds OUTPUT_NODES*ROUNDS-1 (97 at defaults). There is no wrap-around.

Optional Feature:
- Macro FC_SCHED_PERF_EN.
- When defined:
  - Adds output perf_cycles, 16 bits.
  - Cleared when start is accepted.
  - Increments every cycle busy=1, including stalled cycles.
  - Saturates at 0xFFFF.
  - Holds its value after done until the next start.
  - Resets to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Defaults, start pulse, no stall:
  - 49 issue_vld cycles with w_addr 0..48, then 49 cycles with 49..97.
  - acc_en count 100, acc_clr count 2, bias_sel count 2.
  - out_wr at node_idx 0 then 1.
  - done exactly 107 cycles after start accepted.
- stall held 5 cycles mid-ISSUE at round 20:
  - No issue_vld/acc_en while stalled; addresses frozen at 20.
  - Sequence resumes at round 20; done arrives 112 cycles after start.
- reset asserted in DRAIN of node 1:
  - Next cycle all outputs 0, no out_wr, no done.
  - A new start then runs a full 107-cycle job.
- start held high continuously:
  - Back-to-back jobs, each 107 cycles, done pulses 108 cycles apart.
  - start is ignored while busy.
- PIPE_LAT=4, INPUT_NODES=64, MAC_UNITS=16, OUTPUT_NODES=3:
  - Per node: 4 issues, first acc_en 4 cycles after first issue_vld.
  - done at 3*10+1 = 31 cycles.
- FC_SCHED_PERF_EN defined, defaults, 3 stall cycles: perf_cycles reads 109 after done.
